// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a conversion requester and the
// bin2bcd double-dabble converter.
interface bin2bcd_if #(parameter int BIN_W = 27);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [31:0]      bcd;

  modport master (output start, output bin, input busy, input done, input ovf, input bcd);
  modport slave  (input start, input bin, output busy, output done, output ovf, output bcd);
endinterface

// File: rtl/bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// saturation to 9999_9999 for inputs that do not fit in eight decimal digits.
module bin2bcd #(
  parameter int BIN_W = 27
) (
  input logic     clk,
  input logic     rst_n,
  bin2bcd_if.slave bus
);

  localparam int              CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BIN_W - 1);
  localparam logic [31:0]     BIN_MAX = 32'd99_999_999;
  localparam logic [31:0]     BCD_SAT = 32'h9999_9999;

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state, state_next;
  logic [BIN_W-1:0] sr;
  logic [31:0]      acc;
  logic [31:0]      acc_adj;
  logic [31:0]      acc_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      bcd_r;
  logic             done_r;
  logic             ovf_r;
  logic             bin_over;
  logic             accept;
  logic             sat;
  logic             finish;

  // Pre-shift correction: any digit >= 5 would carry past 9 once doubled.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] a);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 8; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bin_over = 32'(bus.bin) > BIN_MAX;
  assign acc_adj  = dabble_adjust(acc);
  assign acc_next = 32'({acc_adj, sr[BIN_W-1]});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sat        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bin_over) begin
            sat = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = CONV;
          end
        end
      end
      CONV: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bcd/ovf only move on a done edge, so a partial accumulator is never visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_r  <= '0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        sr  <= bus.bin;
        acc <= '0;
        cnt <= '0;
      end else if (sat) begin
        bcd_r  <= BCD_SAT;
        ovf_r  <= 1'b1;
        done_r <= 1'b1;
      end else if (state == CONV) begin
        sr  <= sr << 1;
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
        if (finish) begin
          bcd_r  <= acc_next;
          ovf_r  <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  // The capture cycle right after acceptance is not reported as busy.
  assign bus.busy = (state == CONV) && (cnt != '0);
  assign bus.done = done_r;
  assign bus.ovf  = ovf_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_bin2bcd.sv
// Directed and model-checked stimulus for bin2bcd at BIN_W=27, sampling
// outputs on the falling clock edge.
module tb_bin2bcd;

  localparam int BIN_W = 27;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin2bcd_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input logic [26:0] v);
    logic [31:0] r;
    int          x;
    if (v > 27'd99_999_999) return 32'h9999_9999;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Launch one request and follow it to its done pulse; index 0 is the
  // cycle after the accepting edge.
  task automatic do_conv(input string tag, input logic [26:0] v,
                         input logic [31:0] exp_bcd, input logic exp_ovf);
    int          lat;
    int          exp_lat;
    logic [31:0] prev_bcd;
    bit          busy_bad;
    bit          hold_bad;
    exp_lat  = exp_ovf ? 0 : BIN_W;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    @(negedge clk);
    prev_bcd  = bus.bcd;
    bus.start = 1'b1;
    bus.bin   = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 27'($urandom);
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy !== (lat >= 1)) busy_bad = 1'b1;
      if (bus.bcd !== prev_bcd) hold_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_bcd"}, bus.bcd, exp_bcd);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    check({tag, "_bcd_held"}, 32'(hold_bad), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [26:0] v;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.bin   = 27'd123;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    check("rst_bcd",  bus.bcd,       32'h0000_0000);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    do_conv("v12345678", 27'd12_345_678,  32'h1234_5678, 1'b0);
    do_conv("v99999999", 27'd99_999_999,  32'h9999_9999, 1'b0);
    do_conv("v1e8",      27'd100_000_000, 32'h9999_9999, 1'b1);
    do_conv("v0",        27'd0,           32'h0000_0000, 1'b0);
    do_conv("v9",        27'd9,           32'h0000_0009, 1'b0);
    do_conv("vmax",      27'h7FF_FFFF,    32'h9999_9999, 1'b1);

    // Start during CONV is ignored; start in the done cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd1_000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd7_654_321;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 27'd0;
    lat = 5;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, BIN_W);
    check("ign_bcd", bus.bcd, 32'h0000_1000);
    check("ign_ovf", 32'(bus.ovf), 32'd0);
    bus.start = 1'b1;
    bus.bin   = 27'd7_654_321;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 27'd3;
    check("b2b_done_width", 32'(bus.done), 32'd0);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat", lat, BIN_W);
    check("b2b_bcd", bus.bcd, 32'h0765_4321);

    // Leave ovf=1 and bcd nonzero, then abort a conversion with reset.
    do_conv("presat", 27'd100_000_000, 32'h9999_9999, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd55_555_555;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.bin   = 27'd5;
    @(negedge clk);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ovf",  32'(bus.ovf),  32'd0);
    check("abort_bcd",  bus.bcd,       32'h0000_0000);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    check("abort_quiet", pulses, 0);
    do_conv("v42", 27'd42, 32'h0000_0042, 1'b0);

    for (int i = 0; i < 200; i++) begin
      v = 27'($urandom_range(0, (1 << 27) - 1));
      do_conv("rand", v, ref_bcd(v), v > 27'd99_999_999);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
